// File: rtl/cs_y_serializer.sv
// cs_y_serializer
//   Takes the CS window-filter result stream (one 10-bit word per clk),
//   skips the words produced while the filter window is still filling,
//   keeps one of every DECIM remaining words, buffers them in a small FIFO
//   and sends each one as a 2-byte packet on a valid/ready byte interface.
//
//   Packet: byte 0 = {3'b101, seq[2:0], Y[9:8]}, byte 1 = Y[7:0].
//   seq advances on every capture attempt, including dropped ones, so the
//   receiver can spot gaps.
//
// Ports
//   clk         system clock, all logic on posedge
//   reset       asynchronous active-high reset
//   Y[9:0]      CS result word, sampled every posedge
//   en          capture enable
//   out_data    byte to sink (registered)
//   out_valid   out_data is valid (registered)
//   out_ready   sink accepts the byte this cycle
//   ovf         sticky: at least one word was dropped on a full FIFO
//   drop_cnt    saturating count of dropped words
//   fifo_level  occupied FIFO entries (includes the word being sent)
//
// DEPTH must be a power of two >= 2 and <= 8 (fifo_level is 4 bits wide);
// DECIM must be >= 1.

module cs_y_serializer #(
    parameter int WARMUP = 9,
    parameter int DECIM  = 2,
    parameter int DEPTH  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] Y,
    input  logic       en,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       ovf,
    output logic [7:0] drop_cnt,
    output logic [3:0] fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HI,
        S_LO
    } state_t;

    state_t          state;
    logic [WW-1:0]   warm_cnt;
    logic [PW-1:0]   phase;
    logic [2:0]      seq;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_next;
    logic [12:0]     mem [DEPTH];

    logic            eligible;
    logic            capture;
    logic            pop;
    logic            full;
    logic            wr_ok;
    logic            drop;
    logic [12:0]     head_word;
    logic [12:0]     next_word;

    function automatic logic [7:0] header_of(input logic [12:0] w);
        return {3'b101, w[12:10], w[9:8]};
    endfunction

    // Capture/pop decisions for this edge. A full FIFO still accepts a write
    // when the head is being popped in the same cycle, so the level stays put.
    always_comb begin
        eligible  = (warm_cnt == WW'(WARMUP));
        capture   = eligible && en && (phase == '0);
        pop       = (state == S_LO) && out_ready;
        full      = (fifo_level == 4'(DEPTH));
        wr_ok     = capture && (!full || pop);
        drop      = capture && full && !pop;
        rd_next   = rd_ptr + 1'b1;
        head_word = mem[rd_ptr];
        next_word = mem[rd_next];
    end

    // Warm-up counter saturates at WARMUP, which marks the stream eligible.
    // The decimation phase only moves on eligible edges with en high, so
    // pausing en resumes at the same phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_cnt <= '0;
            phase    <= '0;
            seq      <= '0;
        end else begin
            if (!eligible) begin
                warm_cnt <= warm_cnt + 1'b1;
            end
            if (eligible && en) begin
                phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
            end
            if (capture) begin
                seq <= seq + 1'b1;
            end
        end
    end

    // FIFO storage has no reset; only the pointers and level define content.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= {seq, Y};
        end
    end

    // FIFO pointers, level and the drop bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            ovf        <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({wr_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    // Output FSM with registered byte and valid. Leaving S_LO, the next
    // header comes straight from the entry behind the head when one is
    // already stored, giving back-to-back bytes; a word arriving in that
    // same cycle is picked up through S_IDLE instead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fifo_level != 4'd0) begin
                        out_data  <= header_of(head_word);
                        out_valid <= 1'b1;
                        state     <= S_HI;
                    end
                end
                S_HI: begin
                    if (out_ready) begin
                        out_data <= head_word[7:0];
                        state    <= S_LO;
                    end
                end
                S_LO: begin
                    if (out_ready) begin
                        if (fifo_level > 4'd1) begin
                            out_data <= header_of(next_word);
                            state    <= S_HI;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cs_y_serializer.sv
// tb_cs_y_serializer
//   Directed bench for cs_y_serializer. A queue-based reference model
//   predicts the outputs after every clock edge; literal expectations on the
//   received byte stream and a few status values pin the model itself.

module tb_cs_y_serializer;

    localparam int WARMUP = 9;
    localparam int DECIM  = 2;
    localparam int DEPTH  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] y = '0;
    logic       en = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       ovf;
    logic [7:0] drop_cnt;
    logic [3:0] fifo_level;

    int vectors = 0;
    int miscompares = 0;

    cs_y_serializer #(.WARMUP(WARMUP), .DECIM(DECIM), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .Y          (y),
        .en         (en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ovf        (ovf),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Reference model state: words waiting as {seq, Y}, packet progress as
    // 0 = nothing on the bus, 1 = header shown, 2 = low byte shown.
    logic [12:0] q[$];
    int          m_warm;
    int          m_cnt;
    int          m_seq;
    int          m_st;
    bit          m_valid;
    logic [7:0]  m_data;
    bit          m_ovf;
    int          m_drops;
    bit          model_on = 1'b0;

    // Bytes the sink actually accepted, with the edge number of acceptance.
    logic [7:0]  rx[$];
    int          rx_cyc[$];
    int          cyc = 0;
    bit          dv = 1'b0;
    logic [7:0]  dd = '0;

    function automatic logic [7:0] hdr(input logic [12:0] w);
        return {3'b101, w[12:10], w[9:8]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        q.delete();
        m_warm  = 0;
        m_cnt   = 0;
        m_seq   = 0;
        m_st    = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs that
    // were stable across the edge.
    task automatic modelStep();
        bit          pop;
        bit          cap;
        logic [12:0] w;
        pop = (m_st == 2) && out_ready;
        cap = 1'b0;
        if (m_warm >= WARMUP && en) begin
            cap   = (m_cnt == 0);
            m_cnt = (m_cnt + 1) % DECIM;
        end
        if (m_warm < WARMUP) m_warm++;
        case (m_st)
            0: if (q.size() > 0) begin
                   m_data  = hdr(q[0]);
                   m_valid = 1'b1;
                   m_st    = 1;
               end
            1: if (out_ready) begin
                   w      = q[0];
                   m_data = w[7:0];
                   m_st   = 2;
               end
            default: if (out_ready) begin
                   if (q.size() > 1) begin
                       m_data = hdr(q[1]);
                       m_st   = 1;
                   end else begin
                       m_valid = 1'b0;
                       m_st    = 0;
                   end
               end
        endcase
        if (pop) void'(q.pop_front());
        if (cap) begin
            if (q.size() < DEPTH) begin
                w = {3'(m_seq), y};
                q.push_back(w);
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
            m_seq = (m_seq + 1) % 8;
        end
    endtask

    // Single compare process: advance the model on every edge (or on reset),
    // then check the DUT 1 time unit later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            modelReset();
            dv = 1'b0;
        end else begin
            cyc++;
            if (dv && out_ready) begin
                rx.push_back(dd);
                rx_cyc.push_back(cyc);
            end
            modelStep();
        end
        #1;
        if (model_on) begin
            checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) checkOutput("out_data", 32'(out_data), 32'(m_data));
            checkOutput("ovf", 32'(ovf), 32'(m_ovf));
            checkOutput("drop_cnt", 32'(drop_cnt), 32'(m_drops));
            checkOutput("fifo_level", 32'(fifo_level), 32'(q.size()));
        end
        dv = out_valid;
        dd = out_data;
    end

    // Drive one set of inputs at the falling edge and return just after
    // the following rising edge.
    task automatic applyStimulus(input logic [9:0] yv, input logic e, input logic r);
        @(negedge clk);
        y = yv;
        en = e;
        out_ready = r;
        @(posedge clk);
        #2;
    endtask

    task automatic assertReset();
        reset = 1'b1;
        #1;
        checkOutput("rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst out_data", 32'(out_data), 32'd0);
        checkOutput("rst ovf", 32'(ovf), 32'd0);
        checkOutput("rst drop_cnt", 32'(drop_cnt), 32'd0);
        checkOutput("rst fifo_level", 32'(fifo_level), 32'd0);
    endtask

    // Release reset and run the WARMUP edges (edge 0 included).
    task automatic releaseAndWarm(input logic [9:0] yv, input logic r);
        @(negedge clk);
        reset = 1'b0;
        rx.delete();
        rx_cyc.delete();
        y = yv;
        en = 1'b1;
        out_ready = r;
        @(posedge clk);
        #2;
        repeat (WARMUP - 1) applyStimulus(yv, 1'b1, r);
    endtask

    logic [7:0] exp_g [8];
    int         exp_seq [9];

    initial begin
        model_on = 1'b1;

        // Reset state and warm-up
        @(negedge clk);
        assertReset();
        releaseAndWarm(10'h3FF, 1'b1);
        checkOutput("warmup no valid", 32'(out_valid), 32'd0);
        checkOutput("warmup no bytes", 32'(rx.size()), 32'd0);
        repeat (5) applyStimulus(10'h155, 1'b1, 1'b1);
        checkOutput("warmup byte count>=2", 32'(rx.size() >= 2), 32'd1);
        checkOutput("warmup header", 32'(rx[0]), 32'hA1);
        checkOutput("warmup low", 32'(rx[1]), 32'h55);

        // Decimation with a continuous sink
        @(negedge clk);
        assertReset();
        releaseAndWarm(10'h000, 1'b1);
        for (int i = 1; i <= 6; i++) applyStimulus(10'(i), 1'b1, 1'b1);
        repeat (10) applyStimulus(10'h000, 1'b0, 1'b1);
        exp_g = '{8'hA0, 8'h01, 8'hA4, 8'h03, 8'hA8, 8'h05, 8'h00, 8'h00};
        checkOutput("decim count", 32'(rx.size()), 32'd6);
        for (int i = 0; i < 6; i++) checkOutput("decim byte", 32'(rx[i]), 32'(exp_g[i]));
        checkOutput("decim continuous", 32'(rx_cyc[5] - rx_cyc[0]), 32'd5);
        checkOutput("decim ovf", 32'(ovf), 32'd0);

        // Backpressure, overflow, then a full-FIFO write alongside a pop
        @(negedge clk);
        assertReset();
        releaseAndWarm(10'h000, 1'b0);
        for (int i = 0; i < 19; i++) applyStimulus(10'h200 + 10'(i), 1'b1, 1'b0);
        checkOutput("bp level", 32'(fifo_level), 32'd8);
        checkOutput("bp ovf", 32'(ovf), 32'd1);
        checkOutput("bp drop_cnt", 32'(drop_cnt), 32'd2);
        checkOutput("bp held valid", 32'(out_valid), 32'd1);
        checkOutput("bp held header", 32'(out_data), 32'hA2);
        applyStimulus(10'h213, 1'b1, 1'b1);
        applyStimulus(10'h214, 1'b1, 1'b1);
        checkOutput("popwr level", 32'(fifo_level), 32'd8);
        checkOutput("popwr drop_cnt", 32'(drop_cnt), 32'd2);
        repeat (30) applyStimulus(10'h000, 1'b0, 1'b1);
        exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 2};
        checkOutput("bp byte count", 32'(rx.size()), 32'd18);
        for (int k = 0; k < 9; k++) begin
            logic [7:0] h;
            h = rx[2 * k];
            checkOutput("bp header seq", 32'(h[4:2]), 32'(exp_seq[k]));
        end
        checkOutput("bp last low", 32'(rx[17]), 32'h14);

        // en gating holds the decimation phase
        @(negedge clk);
        assertReset();
        releaseAndWarm(10'h000, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(10'h040 + 10'(i), !(i >= 3 && i <= 7), 1'b1);
        repeat (12) applyStimulus(10'h000, 1'b0, 1'b1);
        exp_g = '{8'hA0, 8'h40, 8'hA4, 8'h42, 8'hA8, 8'h49, 8'hAC, 8'h4B};
        checkOutput("en byte count", 32'(rx.size()), 32'd8);
        for (int i = 0; i < 8; i++) checkOutput("en byte", 32'(rx[i]), 32'(exp_g[i]));

        // Reset in the middle of a packet, then a complete fresh warm-up
        @(negedge clk);
        assertReset();
        releaseAndWarm(10'h3FF, 1'b1);
        repeat (3) applyStimulus(10'h155, 1'b1, 1'b1);
        checkOutput("midpkt valid", 32'(out_valid), 32'd1);
        checkOutput("midpkt low byte", 32'(out_data), 32'h55);
        assertReset();
        releaseAndWarm(10'h3FF, 1'b1);
        checkOutput("rewarm no valid", 32'(out_valid), 32'd0);
        checkOutput("rewarm no bytes", 32'(rx.size()), 32'd0);
        repeat (5) applyStimulus(10'h155, 1'b1, 1'b1);
        checkOutput("rewarm header", 32'(rx[0]), 32'hA1);
        checkOutput("rewarm low", 32'(rx[1]), 32'h55);

        // drop_cnt saturation
        @(negedge clk);
        assertReset();
        releaseAndWarm(10'h000, 1'b0);
        repeat (600) applyStimulus(10'h003, 1'b1, 1'b0);
        checkOutput("sat drop_cnt", 32'(drop_cnt), 32'hFF);
        checkOutput("sat ovf", 32'(ovf), 32'd1);
        checkOutput("sat level", 32'(fifo_level), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cs_y_serializer.md
Name: cs_y_serializer

Overview:
- Downstream consumer of the CS window-filter output Y[9:0]; CS produces one word per clk.
- Discards the warm-up words produced while the 9-sample window fills, then decimates the stream and buffers it in a small FIFO.
- Emits each word as a 2-byte framed packet on a valid/ready byte interface toward the off-chip writer.

Parameters:
- WARMUP, 9: clk edges after reset release during which Y is ignored.
- DECIM, 2: capture one of every DECIM eligible words; must be >= 1.
- DEPTH, 8: FIFO entries, power of 2; each entry holds Y[9:0] plus seq[2:0].

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- Y  input  10  CS result word, sampled every posedge.
- en  input  1  capture enable.
- out_data  output  8  byte to sink.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts the byte this cycle.
- ovf  output  1  sticky flag: at least one word dropped.
- drop_cnt  output  8  count of dropped words, saturating.
- fifo_level  output  4  number of occupied FIFO entries, 0..DEPTH.

Behaviour:
- Reset, applied asynchronously: out_data=0, out_valid=0, ovf=0, drop_cnt=0, fifo_level=0. The sequence counter, warm-up counter, decimation phase and FSM (S_IDLE) are also cleared. Reset asserted mid-packet drops out_valid at once; the partial packet and all FIFO contents are lost.
- Warm-up:
  - Index posedges after reset deassertion as 0,1,2,...
  - Y is ignored on edges 0..WARMUP-1; it is eligible from edge WARMUP on.
  - The counter saturates.
- Decimation:
  - The phase counter runs 0..DECIM-1 and advances only on eligible edges with en=1.
  - A capture happens at phase 0, so the first eligible enabled word is always captured.
  - With en=0 the phase counter holds.
- Capture and sequence number:
  - Each capture attempt stores {seq, Y} and then increments seq (3-bit, wraps 7->0).
  - seq also increments for dropped words, so the receiver sees gaps.
- FIFO:
  - A word is popped on the low-byte handshake.
  - A capture when fifo_level==DEPTH is dropped, except when a pop occurs in the same cycle; then the write is accepted and the level stays at DEPTH.
  - A drop sets ovf, which stays set until reset. drop_cnt increments and saturates at 255.
  - The write and read pointers wrap modulo DEPTH.
  - fifo_level counts the word currently being transmitted.
- Packet format:
  - Byte 0 (header) = {3'b101, seq[2:0], Y[9:8]}.
  - Byte 1 = Y[7:0].
- Output FSM (out_data and out_valid are registered):
  - S_IDLE: out_valid=0. If fifo_level!=0, load the header of the head entry and go to S_HI.
  - S_HI: out_valid=1, out_data=header. If out_ready, load the low byte and go to S_LO; otherwise hold.
  - S_LO: out_valid=1, out_data=low byte. If out_ready, pop. Then go to S_HI with the next header if an entry remains after the pop, else go to S_IDLE.
  - The S_LO to S_HI path gives back-to-back bytes at 1 byte/cycle. With DECIM=2 and out_ready held at 1, the FIFO never overflows.
- Handshake rule: while out_valid=1 and out_ready=0, out_data is held stable.
- Latency: a word captured at edge k is in the FIFO after edge k. The header is valid after edge k+1 and the low byte after edge k+2 (out_ready=1, FIFO empty before capture).
- en does not affect words already in the FIFO.
- No combinational path from out_ready to out_valid or out_data.

Test Plan:
- Warm-up: reset, then Y=10'h3FF for 9 edges, then Y=10'h155 with out_ready=1. Required: no out_valid during warm-up; first packet is 8'hA1, 8'h55 (seq 0, header 101_000_01).
- Decimation: DECIM=2, out_ready=1, eligible Y sequence 1,2,3,4,5,6. Required: packets carry Y=1,3,5 with seq 0,1,2; output is continuous; ovf=0.
- Backpressure: out_ready=0 for 20 cycles with a steady stream. Required:
  - out_data is held at the first header; fifo_level reaches 8.
  - The next two capture attempts are dropped: ovf=1, drop_cnt=2.
  - After out_ready rises, headers carry seq 0..7, then seq 2 (after wrap), exposing the gap.
- Simultaneous pop and full write: FIFO full, the S_LO handshake coincides with a capture. Required: the word is accepted, fifo_level stays 8, drop_cnt unchanged.
- en gating: en=0 for 5 eligible edges mid-stream. Required: no captures, phase held; resumption captures at the held phase.
- Mid-packet reset: assert reset while in S_LO. Required: out_valid=0 immediately; all outputs return to reset values; after release the full warm-up repeats.
- Saturation: force more than 255 drops. Required: drop_cnt stays 8'hFF.
